// File: rtl/conv_core_gen2_if.sv
// Bus bundle for conv_core_gen2: job control, X/Y read ports, Z write port
// and status. The core attaches through the slave modport; whoever drives
// jobs and models the memories uses the master modport.
interface conv_core_gen2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] sizeX_in;
  logic [ADDR_WIDTH-1:0] sizeY_in;
  logic                  mode_in;
  logic                  signed_in;
  logic [ADDR_WIDTH-1:0] memX_addr;
  logic [DATA_WIDTH-1:0] dataX;
  logic [ADDR_WIDTH-1:0] memY_addr;
  logic [DATA_WIDTH-1:0] dataY;
  logic [ADDR_WIDTH:0]   memZ_addr;
  logic [OUT_WIDTH-1:0]  dataZ;
  logic                  writeZ;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, abort, sizeX_in, sizeY_in, mode_in, signed_in, dataX, dataY,
    input  memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done, err
  );

  modport slave (
    input  start, abort, sizeX_in, sizeY_in, mode_in, signed_in, dataX, dataY,
    output memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy, done, err
  );
endinterface

// File: rtl/conv_core_gen2.sv
// 1-D convolution engine z[n] = sum_k x[k]*y[n-k], full or valid output,
// signed or unsigned operands, reading X/Y from 1-cycle-latency memories.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for start, outputs hold
//   S_SETUP  | check latched config, choose first/last output index
//   S_READ   | issue one X/Y address pair per cycle for current output
//   S_DRAIN1 | read data of last pair returning
//   S_DRAIN2 | last product registered, final accumulate at cycle end
//   S_WRITE  | write accumulator to Z[out_idx]
//   S_DONE   | one-cycle done pulse
module conv_core_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int OUT_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input logic             clk,
  input logic             rstn,
  conv_core_gen2_if.slave bus
);

  localparam int NW = ADDR_WIDTH + 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [NW-1:0] ONE_N = NW'(1);
  localparam logic [NW-1:0] TWO_N = NW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_READ, S_DRAIN1, S_DRAIN2, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] size_x, size_y, x_addr, y_addr, rd_cnt;
  logic                  mode_r, sgn_r, err_r;
  logic [NW-1:0]         n_cur, n_last, out_idx;
  logic                  d_v, p_v;
  logic [PW-1:0]         prod;
  logic [OUT_WIDTH-1:0]  acc, acc_nxt, data_z, prod_ext;

  logic                  abort_act, cfg_bad, enter_read;
  logic                  busy_c, write_c, done_c;
  logic [NW-1:0]         sx_e, sy_e, n_go, n_last_cfg;
  logic [ADDR_WIDTH-1:0] kmin_go, kmax_go, y_go, ld_cnt;
  logic signed [DATA_WIDTH:0] xa, ya;
  logic signed [PW-1:0]  pfull;

  assign abort_act = bus.abort && (state != S_IDLE);
  assign cfg_bad   = (size_x == '0) || (size_y == '0) || (mode_r && (size_x < size_y));

  // Next-state and strobe decode; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    busy_c    = (state != S_IDLE);
    write_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = cfg_bad ? S_DONE : S_READ;
      S_READ:   if (rd_cnt == '0) state_nxt = S_DRAIN1;
      S_DRAIN1: state_nxt = S_DRAIN2;
      S_DRAIN2: state_nxt = S_WRITE;
      S_WRITE: begin
        write_c   = 1'b1;
        state_nxt = (n_cur == n_last) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_act) begin
      state_nxt = S_IDLE;
      write_c   = 1'b0;
      done_c    = 1'b0;
    end
  end

  // Window of the output about to be read: kmin/kmax bounds and first addresses.
  always_comb begin
    sx_e       = {1'b0, size_x};
    sy_e       = {1'b0, size_y};
    n_go       = (state == S_SETUP) ? (mode_r ? sy_e - ONE_N : '0) : n_cur + ONE_N;
    n_last_cfg = mode_r ? sx_e - ONE_N : sx_e + sy_e - TWO_N;
    // true results always fit ADDR_WIDTH, so modular AW-bit arithmetic is exact
    kmin_go    = ((n_go + ONE_N) >= sy_e) ? n_go[ADDR_WIDTH-1:0] - size_y + 1'b1 : '0;
    kmax_go    = (n_go < (sx_e - ONE_N)) ? n_go[ADDR_WIDTH-1:0] : size_x - 1'b1;
    y_go       = n_go[ADDR_WIDTH-1:0] - kmin_go;
    ld_cnt     = kmax_go - kmin_go;
    enter_read = (state_nxt == S_READ) && (state != S_READ);
  end

  // Operand extension and multiply; PW-bit context keeps the low product bits exact.
  always_comb begin
    xa       = {sgn_r & bus.dataX[DATA_WIDTH-1], bus.dataX};
    ya       = {sgn_r & bus.dataY[DATA_WIDTH-1], bus.dataY};
    pfull    = xa * ya;
    prod_ext = {{(OUT_WIDTH-PW){sgn_r & prod[PW-1]}}, prod};
    acc_nxt  = acc + (p_v ? prod_ext : '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Job configuration latch and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      size_x <= '0;
      size_y <= '0;
      mode_r <= 1'b0;
      sgn_r  <= 1'b0;
      err_r  <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      size_x <= bus.sizeX_in;
      size_y <= bus.sizeY_in;
      mode_r <= bus.mode_in;
      sgn_r  <= bus.signed_in;
      err_r  <= 1'b0;
    end else if (state == S_SETUP && cfg_bad && !bus.abort) begin
      err_r  <= 1'b1;
    end
  end

  // Output index, read addresses and the per-output read down-counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_cur   <= '0;
      n_last  <= '0;
      out_idx <= '0;
      x_addr  <= '0;
      y_addr  <= '0;
      rd_cnt  <= '0;
    end else if (enter_read) begin
      n_cur  <= n_go;
      x_addr <= kmin_go;
      y_addr <= y_go;
      rd_cnt <= ld_cnt;
      if (state == S_SETUP) begin
        out_idx <= '0;
        n_last  <= n_last_cfg;
      end else begin
        out_idx <= out_idx + ONE_N;
      end
    end else if (state == S_READ && !bus.abort && rd_cnt != '0) begin
      rd_cnt <= rd_cnt - 1'b1;
      x_addr <= x_addr + 1'b1;
      y_addr <= y_addr - 1'b1;
    end
  end

  // Read-data -> product -> accumulate pipeline; abort kills in-flight terms.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      d_v  <= 1'b0;
      p_v  <= 1'b0;
      prod <= '0;
    end else begin
      d_v <= (state == S_READ) && !bus.abort;
      p_v <= d_v && !abort_act;
      if (d_v) prod <= pfull;
    end
  end

  // Accumulator cleared per output; result register loaded with the final sum.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc    <= '0;
      data_z <= '0;
    end else begin
      if (enter_read) acc <= '0;
      else if (p_v)   acc <= acc_nxt;
      if (state == S_DRAIN2 && !bus.abort) data_z <= acc_nxt;
    end
  end

  assign bus.memX_addr = x_addr;
  assign bus.memY_addr = y_addr;
  assign bus.memZ_addr = out_idx;
  assign bus.dataZ     = data_z;
  assign bus.writeZ    = write_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_conv_core_gen2.sv
// Directed bench for conv_core_gen2 with behavioural X/Y/Z memories.
module tb_conv_core_gen2;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int OW = 2*DW+AW;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  conv_core_gen2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) bus();

  conv_core_gen2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DW-1:0] x_mem [32];
  logic [DW-1:0] y_mem [32];
  logic [OW-1:0] z_mem [64];
  int cyc = 0, wr_total = 0, done_total = 0;
  int n_vec = 0, n_bad = 0;

  // registered-read memories and cycle counter
  always @(posedge clk) begin
    bus.dataX <= x_mem[bus.memX_addr];
    bus.dataY <= y_mem[bus.memY_addr];
    cyc       <= cyc + 1;
  end

  // Z write port and done monitor
  always @(negedge clk) begin
    if (bus.writeZ === 1'b1) begin
      z_mem[bus.memZ_addr] = bus.dataZ;
      wr_total++;
    end
    if (bus.done === 1'b1) done_total++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // start one job; returns cycles from the start cycle to the done pulse
  task automatic run_job(input int sx, input int sy, input bit md, input bit sg,
                         input int poke, input int budget, output int lat);
    int st;
    @(posedge clk); #1;
    bus.sizeX_in  = AW'(sx);
    bus.sizeY_in  = AW'(sy);
    bus.mode_in   = md;
    bus.signed_in = sg;
    bus.start     = 1'b1;
    st  = cyc;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      bus.start = (i == poke);
      if (i == poke) begin
        bus.sizeX_in = AW'(1);
        bus.mode_in  = 1'b1;
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = cyc - st;
        break;
      end
    end
    bus.start = 1'b0;
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_memX_addr"}, 64'(bus.memX_addr), 0);
    chk({pfx, "_memY_addr"}, 64'(bus.memY_addr), 0);
    chk({pfx, "_memZ_addr"}, 64'(bus.memZ_addr), 0);
    chk({pfx, "_dataZ"},     64'(bus.dataZ), 0);
    chk({pfx, "_writeZ"},    64'(bus.writeZ), 0);
    chk({pfx, "_busy"},      64'(bus.busy), 0);
    chk({pfx, "_done"},      64'(bus.done), 0);
    chk({pfx, "_err"},       64'(bus.err), 0);
  endtask

  task automatic load_small();
    x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
    y_mem[0] = 8'd1; y_mem[1] = 8'd1;
  endtask

  initial begin
    int lat, wb, db, exp_lat;
    logic [63:0] sum;
    int terms;

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.sizeX_in = '0; bus.sizeY_in = '0; bus.mode_in = 1'b0; bus.signed_in = 1'b0;
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = '0;
      y_mem[i] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1 rstn = 1'b1;

    // full mode, unsigned
    load_small();
    wb = wr_total;
    run_job(3, 2, 1'b0, 1'b0, 0, 100, lat);
    chk("full_latency", 64'(lat), 20);
    chk("full_err", 64'(bus.err), 0);
    @(negedge clk);
    chk("full_busy_after", 64'(bus.busy), 0);
    chk("full_writes", 64'(wr_total - wb), 4);
    chk("full_z0", 64'(z_mem[0]), 1);
    chk("full_z1", 64'(z_mem[1]), 3);
    chk("full_z2", 64'(z_mem[2]), 5);
    chk("full_z3", 64'(z_mem[3]), 3);

    // valid mode, same data
    wb = wr_total;
    run_job(3, 2, 1'b1, 1'b0, 0, 100, lat);
    chk("valid_latency", 64'(lat), 12);
    chk("valid_err", 64'(bus.err), 0);
    @(negedge clk);
    chk("valid_writes", 64'(wr_total - wb), 2);
    chk("valid_z0", 64'(z_mem[0]), 3);
    chk("valid_z1", 64'(z_mem[1]), 5);

    // signed vs unsigned single sample
    x_mem[0] = 8'hFF; y_mem[0] = 8'h02;
    run_job(1, 1, 1'b0, 1'b1, 0, 100, lat);
    chk("signed_latency", 64'(lat), 6);
    @(negedge clk);
    chk("signed_dataZ", 64'(bus.dataZ), 64'h1FFFFE);
    run_job(1, 1, 1'b0, 1'b0, 0, 100, lat);
    @(negedge clk);
    chk("unsigned_dataZ", 64'(bus.dataZ), 64'h0001FE);

    // illegal configurations
    load_small();
    wb = wr_total;
    run_job(3, 0, 1'b0, 1'b0, 0, 20, lat);
    chk("err_sy0_latency", 64'(lat), 2);
    chk("err_sy0_err", 64'(bus.err), 1);
    repeat (3) @(negedge clk);
    chk("err_sy0_sticky", 64'(bus.err), 1);
    chk("err_sy0_writes", 64'(wr_total - wb), 0);
    wb = wr_total;
    run_job(2, 3, 1'b1, 1'b0, 0, 20, lat);
    chk("err_valid_latency", 64'(lat), 2);
    chk("err_valid_err", 64'(bus.err), 1);
    @(negedge clk);
    chk("err_valid_writes", 64'(wr_total - wb), 0);
    run_job(3, 2, 1'b0, 1'b0, 0, 100, lat);
    chk("err_cleared", 64'(bus.err), 0);

    // maximum size, all ones, against a direct reference model
    for (int i = 0; i < 31; i++) begin
      x_mem[i] = 8'hFF;
      y_mem[i] = 8'hFF;
    end
    wb = wr_total;
    run_job(31, 31, 1'b0, 1'b0, 0, 3000, lat);
    @(negedge clk);
    chk("max_writes", 64'(wr_total - wb), 61);
    exp_lat = 2;
    for (int n = 0; n < 61; n++) begin
      sum = '0;
      terms = 0;
      for (int k = 0; k < 31; k++) begin
        if (n - k >= 0 && n - k < 31) begin
          sum += 64'(x_mem[k]) * 64'(y_mem[n-k]);
          terms++;
        end
      end
      exp_lat += terms + 3;
      chk($sformatf("max_z%0d", n), 64'(z_mem[n]), sum);
    end
    chk("max_z30_abs", 64'(z_mem[30]), 64'd2015775);
    chk("max_latency", 64'(lat), 64'(exp_lat));
    for (int i = 0; i < 31; i++) begin
      x_mem[i] = '0;
      y_mem[i] = '0;
    end
    load_small();

    // start while busy is ignored
    wb = wr_total;
    run_job(3, 2, 1'b0, 1'b0, 7, 100, lat);
    chk("busy_start_latency", 64'(lat), 20);
    @(negedge clk);
    chk("busy_start_writes", 64'(wr_total - wb), 4);
    chk("busy_start_z0", 64'(z_mem[0]), 1);
    chk("busy_start_z1", 64'(z_mem[1]), 3);
    chk("busy_start_z2", 64'(z_mem[2]), 5);
    chk("busy_start_z3", 64'(z_mem[3]), 3);

    // abort during READ of the second output
    wb = wr_total; db = done_total;
    @(posedge clk); #1;
    bus.sizeX_in = AW'(3); bus.sizeY_in = AW'(2);
    bus.mode_in = 1'b0; bus.signed_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_busy_during", 64'(bus.busy), 1);
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_after", 64'(bus.busy), 0);
    repeat (30) @(negedge clk);
    chk("abort_writes", 64'(wr_total - wb), 1);
    chk("abort_no_done", 64'(done_total - db), 0);
    chk("abort_err", 64'(bus.err), 0);

    // reset in the middle of a job (first WRITE)
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_writeZ_before", 64'(bus.writeZ), 1);
    chk("midrst_dataZ_before", 64'(bus.dataZ), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midrst");
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
